dff_share_arbiter: RTL

- Round-robin arbiter and sequencer that shares one WIDTH-bit D-flip-flop register bank (output Q) between N requesters.
- Each requester raises REQ, receives a one-hot registered grant, and has its DIN slice clocked into Q for up to HOLD cycles.
- A one-cycle release gap follows each grant, then the next requester in rotation is served.
- Sits between lab-level stimulus sources and the shared storage flip-flops.

---
 rtl/dff_share_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dff_share_arbiter.sv
// ---------------------------------------------------------------------------
// dff_share_arbiter
//
// Round-robin arbiter and sequencer sharing one WIDTH-bit register bank (Q)
// between N requesters. A winner gets a registered one-hot grant. While the
// winner keeps its request up, its DIN slice is captured into Q, for up to
// HOLD edges. One RELEASE cycle follows every grant, then IDLE arbitrates
// again, rotating from the last served requester.
//
// Optional feature (compile-time macro ARB_LOCK_EN):
//   Adds the LOCK input. While LOCK[g] and REQ[g] are both high, the HOLD
//   limit is suspended and the grant continues until LOCK[g] drops (with the
//   counter already at 0) or REQ[g] drops.
//
// Handshake: REQ is level-sensitive. A requester owns Q for every cycle its
// GNT bit is high. Each edge inside that window with REQ[g]=1 loads its slice.
// Dropping REQ[g] ends the grant at the next edge, without a capture.
//
// Ports:
//   C          in   clock, rising edge
//   CLR        in   synchronous reset, active-low
//   REQ[N]     in   per-requester request
//   DIN[N*W]   in   data, slice i = DIN[i*WIDTH +: WIDTH]
//   LOCK[N]    in   (ARB_LOCK_EN only) extend grant past HOLD
//   GNT[N]     out  registered one-hot grant
//   Q[W]       out  shared register contents
//   BUSY       out  state != IDLE
//   DBG_STATE  out  FSM state: 0 = IDLE, 1 = GRANT, 2 = RELEASE
// ---------------------------------------------------------------------------
module dff_share_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 1,
    parameter int HOLD  = 4
) (
    input  logic               C,
    input  logic               CLR,
    input  logic [N-1:0]       REQ,
    input  logic [N*WIDTH-1:0] DIN,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]       LOCK,
`endif
    output logic [N-1:0]       GNT,
    output logic [WIDTH-1:0]   Q,
    output logic               BUSY,
    output logic [1:0]         DBG_STATE
);

    localparam int         IW      = $clog2(N);
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     g_q, g_d;

    logic [IW-1:0]     pick;
    logic              pick_vld;
    logic              req_g;
    logic              lock_g;
    logic [WIDTH-1:0]  din_g;
    logic              grant_end;

    assign req_g = REQ[g_q];
    assign din_g = DIN[int'(g_q) * WIDTH +: WIDTH];

`ifdef ARB_LOCK_EN
    assign lock_g = LOCK[g_q];
`else
    assign lock_g = 1'b0;
`endif

    // The grant ends on a dropped request, or when the HOLD budget is used up
    // and no lock is holding it open. The counter sits at 0 under a lock.
    assign grant_end = !req_g || ((cnt_q == 8'd0) && !lock_g);

    // Rotating scan. It starts one past the last served requester and wraps,
    // so LAST itself is considered last.
    always_comb begin : pick_scan
        logic [IW-1:0] cand;
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_q) + k) % N);
            if (!pick_vld && REQ[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // State register plus the datapath registers it sequences.
    always_ff @(posedge C) begin
        if (!CLR) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            last_q  <= IW'(N - 1);
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            g_q     <= g_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pick_vld) state_d = S_GRANT;
            S_GRANT:   if (grant_end) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        gnt_d  = gnt_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        g_d    = g_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (pick_vld) begin
                    g_d         = pick;
                    gnt_d[pick] = 1'b1;
                    cnt_d       = HOLD_M1;
                end
            end
            S_GRANT: begin
                if (req_g) begin
                    q_d = din_g;
                end
                if (grant_end) begin
                    gnt_d  = '0;
                    last_d = g_q;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RELEASE: begin
                gnt_d = '0;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign GNT       = gnt_q;
    assign Q         = q_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DBG_STATE = state_q;

endmodule
